// File: rtl/vio_ingress_buffer_if.sv
// AXI4-Stream bundle used on both sides of vio_ingress_buffer.
//   tdata/tkeep/tlast/tvalid : driven by the master
//   tready                   : driven by the slave
interface vio_ingress_buffer_if #(
  parameter int unsigned DATA_BITS = 512
) ();
  logic [DATA_BITS-1:0]   tdata;
  logic [DATA_BITS/8-1:0] tkeep;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/vio_ingress_buffer.sv
// Store-and-forward packet buffer between an I/O stack receive stream and the
// vIO Switch host sink. Ingress is never back-pressured; only complete packets
// are released. Packets that overflow the buffer or exceed MAX_PKT_BEATS are
// dropped whole. Each released packet carries a route ID from its first beat.
// Ports:
//   aclk, aresetn   : clock, synchronous active-low reset
//   s_axis          : ingress stream (slave modport), tready=1 out of reset
//   m_axis          : egress stream (master modport)
//   m_route         : route ID of the packet currently on m_axis
//   route_default   : route used when the first-beat route field is zero
//   pkt_cnt         : packets released (wraps)
//   drop_cnt        : packets dropped (wraps)
module vio_ingress_buffer #(
  parameter int unsigned DATA_BITS     = 512,
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned MAX_PKT_BEATS = 32,
  parameter int unsigned ROUTE_BITS    = 14
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  vio_ingress_buffer_if.slave   s_axis,
  vio_ingress_buffer_if.master  m_axis,
  output logic [ROUTE_BITS-1:0] m_route,
  input  logic [ROUTE_BITS-1:0] route_default,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           drop_cnt
);
  localparam int unsigned KB = DATA_BITS / 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(MAX_PKT_BEATS + 1);
  localparam int unsigned MW = DATA_BITS + KB + 1;

  typedef enum logic [1:0] {IDLE, FILL, DROP} wr_state_t;

  logic [MW-1:0]         r_mem    [DEPTH];
  logic [ROUTE_BITS-1:0] r_rf_mem [DEPTH];
  logic [DEPTH-1:0]      r_last_vec;

  logic [PW-1:0]         r_wr_ptr, r_cmt_ptr, r_rd_ptr, r_rf_wr, r_rf_rd;
  wr_state_t             r_state;
  logic [CW-1:0]         r_cnt;
  logic [ROUTE_BITS-1:0] r_route;
  logic                  r_s_tready;
  logic [31:0]           r_pkt_cnt, r_drop_cnt;

  logic                  r_s1_valid;
  logic [MW-1:0]         r_s1_data;
  logic [ROUTE_BITS-1:0] r_s1_route;

  logic                  r_m_valid, r_m_last;
  logic [DATA_BITS-1:0]  r_m_data;
  logic [KB-1:0]         r_m_keep;
  logic [ROUTE_BITS-1:0] r_m_route;

  logic                  w_accept, w_full, w_drop_beat, w_write, w_commit;
  logic [PW-1:0]         w_free;
  logic [ROUTE_BITS-1:0] w_first_route, w_commit_route;
  logic [AW-1:0]         w_wr_idx, w_rd_idx;
  logic                  w_avail, w_out_ld, w_issue, w_issue_last;

  assign s_axis.tready = r_s_tready;
  assign m_axis.tvalid = r_m_valid;
  assign m_axis.tdata  = r_m_data;
  assign m_axis.tkeep  = r_m_keep;
  assign m_axis.tlast  = r_m_last;
  assign m_route       = r_m_route;
  assign pkt_cnt       = r_pkt_cnt;
  assign drop_cnt      = r_drop_cnt;

  always_comb begin
    w_accept       = s_axis.tvalid && r_s_tready;
    w_free         = PW'(DEPTH) - (r_wr_ptr - r_rd_ptr);
    w_full         = (w_free == '0);
    w_first_route  = (s_axis.tdata[ROUTE_BITS-1:0] == '0) ? route_default
                                                          : s_axis.tdata[ROUTE_BITS-1:0];
    w_drop_beat    = w_full || ((r_state == FILL) && (r_cnt == CW'(MAX_PKT_BEATS)));
    w_write        = w_accept && (r_state != DROP) && !w_drop_beat;
    w_commit       = w_write && s_axis.tlast;
    w_commit_route = (r_state == IDLE) ? w_first_route : r_route;
    w_wr_idx       = r_wr_ptr[AW-1:0];
    w_rd_idx       = r_rd_ptr[AW-1:0];
    // Two-stage read pipeline: RAM read register (s1) then output register.
    w_avail        = (r_rd_ptr != r_cmt_ptr);
    w_out_ld       = !r_m_valid || m_axis.tready;
    w_issue        = w_avail && (!r_s1_valid || w_out_ld);
    w_issue_last   = r_last_vec[w_rd_idx];
  end

  // Storage and the synchronous RAM read; no reset needed on array contents.
  // The route FIFO is popped when a packet's last beat leaves the RAM and the
  // route travels with each beat, so the route on m_axis is always that
  // packet's FIFO entry while the FIFO never holds more than DEPTH entries.
  always_ff @(posedge aclk) begin
    if (w_write) begin
      r_mem[w_wr_idx]      <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
      r_last_vec[w_wr_idx] <= s_axis.tlast;
    end
    if (w_commit) r_rf_mem[r_rf_wr[AW-1:0]] <= w_commit_route;
    if (w_issue) begin
      r_s1_data  <= r_mem[w_rd_idx];
      r_s1_route <= r_rf_mem[r_rf_rd[AW-1:0]];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_rd_ptr   <= '0;
      r_rf_wr    <= '0;
      r_rf_rd    <= '0;
      r_cnt      <= '0;
      r_route    <= '0;
      r_s_tready <= 1'b0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_s1_valid <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_keep   <= '0;
      r_m_last   <= 1'b0;
      r_m_route  <= '0;
    end else begin
      r_s_tready <= 1'b1;

      if (w_accept) begin
        unique case (r_state)
          IDLE, FILL: begin
            if (w_drop_beat) begin
              r_wr_ptr <= r_cmt_ptr;
              if (s_axis.tlast) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
                r_state    <= IDLE;
              end else begin
                r_state    <= DROP;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
              if (r_state == IDLE) begin
                r_route <= w_first_route;
                r_cnt   <= CW'(1);
              end else begin
                r_cnt   <= r_cnt + CW'(1);
              end
              if (s_axis.tlast) begin
                r_cmt_ptr <= r_wr_ptr + PW'(1);
                r_state   <= IDLE;
              end else begin
                r_state   <= FILL;
              end
            end
          end
          DROP: begin
            if (s_axis.tlast) begin
              r_drop_cnt <= r_drop_cnt + 32'd1;
              r_state    <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end

      if (w_commit) r_rf_wr <= r_rf_wr + PW'(1);

      if (w_issue) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_s1_valid <= 1'b1;
        if (w_issue_last) r_rf_rd <= r_rf_rd + PW'(1);
      end else if (w_out_ld) begin
        r_s1_valid <= 1'b0;
      end

      if (w_out_ld) begin
        r_m_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_m_data  <= r_s1_data[DATA_BITS-1:0];
          r_m_keep  <= r_s1_data[DATA_BITS +: KB];
          r_m_last  <= r_s1_data[MW-1];
          r_m_route <= r_s1_route;
        end
      end

      if (r_m_valid && m_axis.tready && r_m_last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_vio_ingress_buffer.sv
module tb_vio_ingress_buffer;
  localparam int unsigned DB = 64;
  localparam int unsigned RB = 14;

  typedef struct packed {
    logic [DB-1:0]   d;
    logic [DB/8-1:0] k;
    logic            l;
    logic [RB-1:0]   r;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [RB-1:0] m_route;
  logic [RB-1:0] route_default;
  logic [31:0]   pkt_cnt, drop_cnt;

  vio_ingress_buffer_if #(.DATA_BITS(DB)) s_if ();
  vio_ingress_buffer_if #(.DATA_BITS(DB)) m_if ();

  vio_ingress_buffer #(
    .DATA_BITS    (DB),
    .DEPTH        (64),
    .MAX_PKT_BEATS(32),
    .ROUTE_BITS   (RB)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .m_route      (m_route),
    .route_default(route_default),
    .pkt_cnt      (pkt_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 aclk = ~aclk;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sb[$];
  int    n_out = 0;
  int    run = 0;
  int    run_max = 0;
  bit    stall = 1'b0;
  beat_t stall_b, ob, eb;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one packet of nb beats, optionally stopping after 'stop' beats.
  // Beats of packets expected to be released go onto the scoreboard.
  task automatic send_pkt(input int unsigned nb, input logic [RB-1:0] rfield,
                          input bit pass, input int unsigned stop);
    beat_t         b;
    logic [RB-1:0] er;
    er = (rfield == '0) ? route_default : rfield;
    for (int unsigned i = 0; i < stop; i++) begin
      b.d = {$urandom, $urandom};
      if (i == 0) b.d[RB-1:0] = rfield;
      b.k = 8'($urandom);
      b.l = (i == nb - 1);
      b.r = er;
      s_if.tdata  = b.d;
      s_if.tkeep  = b.k;
      s_if.tlast  = b.l;
      s_if.tvalid = 1'b1;
      if (pass) sb.push_back(b);
      @(posedge aclk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget && (sb.size() != 0 || m_if.tvalid); i++)
      @(negedge aclk);
    @(negedge aclk);
    chk(tag, sb.size(), 0);
  endtask

  // Output monitor: scoreboard pop on every handshake, AXI hold rule on stalls.
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall = 1'b0;
      run   = 0;
    end else begin
      ob = {m_if.tdata, m_if.tkeep, m_if.tlast, m_route};
      if (stall) begin
        chk("hold_valid", m_if.tvalid, 1'b1);
        chk("hold_beat", ob, stall_b);
      end
      if (m_if.tvalid && m_if.tready) begin
        n_out++;
        run++;
        if (run > run_max) run_max = run;
        chk("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          eb = sb.pop_front();
          chk("beat", ob, eb);
        end
      end else begin
        run = 0;
      end
      stall   = m_if.tvalid && !m_if.tready;
      stall_b = ob;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    aresetn       = 1'b0;
    s_if.tvalid   = 1'b0;
    s_if.tlast    = 1'b0;
    s_if.tdata    = '0;
    s_if.tkeep    = '0;
    m_if.tready   = 1'b1;
    route_default = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_tready", s_if.tready, 1'b0);
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_m_tdata", m_if.tdata, '0);
    chk("rst_m_tkeep", m_if.tkeep, '0);
    chk("rst_m_tlast", m_if.tlast, 1'b0);
    chk("rst_m_route", m_route, '0);
    chk("rst_pkt_cnt", pkt_cnt, '0);
    chk("rst_drop_cnt", drop_cnt, '0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("s_tready_up", s_if.tready, 1'b1);
    @(posedge aclk);
    #1;

    // Single 3-beat packet, route 5, latency tlast->tvalid = 2 edges
    send_pkt(3, 14'h0005, 1'b1, 3);
    @(negedge aclk);
    chk("lat_n0", m_if.tvalid, 1'b0);
    @(negedge aclk);
    chk("lat_n1", m_if.tvalid, 1'b0);
    @(negedge aclk);
    chk("lat_n2", m_if.tvalid, 1'b1);
    chk("single_route", m_route, 14'h0005);
    drain("single_drain", 50);
    chk("single_pkt_cnt", pkt_cnt, 32'd1);

    // Default route
    route_default = 14'h0123;
    send_pkt(1, 14'h0000, 1'b1, 1);
    drain("defroute_drain", 50);
    chk("defroute_pkt_cnt", pkt_cnt, 32'd2);

    // Overflow: two 32-beat packets retained, 4-beat packet dropped
    m_if.tready = 1'b0;
    @(posedge aclk);
    #1;
    send_pkt(32, 14'h0011, 1'b1, 32);
    send_pkt(32, 14'h0022, 1'b1, 32);
    send_pkt(4, 14'h0033, 1'b0, 4);
    repeat (3) @(negedge aclk);
    chk("ovf_drop_cnt", drop_cnt, 32'd1);
    chk("ovf_pkt_cnt_stalled", pkt_cnt, 32'd2);
    chk("ovf_tvalid_stalled", m_if.tvalid, 1'b1);
    snap = n_out;
    m_if.tready = 1'b1;
    drain("ovf_drain", 200);
    repeat (4) @(negedge aclk);
    chk("ovf_beats_out", n_out - snap, 64);
    chk("ovf_pkt_cnt", pkt_cnt, 32'd4);

    // Oversize 40-beat packet dropped, following 2-beat packet passes
    snap = n_out;
    send_pkt(40, 14'h0044, 1'b0, 40);
    send_pkt(2, 14'h0055, 1'b1, 2);
    drain("oversize_drain", 50);
    chk("oversize_drop_cnt", drop_cnt, 32'd2);
    chk("oversize_beats_out", n_out - snap, 2);
    chk("oversize_pkt_cnt", pkt_cnt, 32'd5);

    // Back-to-back one-beat packets
    repeat (3) @(negedge aclk);
    run_max = 0;
    #1;
    for (int unsigned i = 0; i < 10; i++)
      send_pkt(1, RB'(i + 1), 1'b1, 1);
    drain("b2b_drain", 50);
    chk("b2b_run", run_max, 10);
    chk("b2b_pkt_cnt", pkt_cnt, 32'd15);
    chk("b2b_drop_cnt", drop_cnt, 32'd2);

    // Reset after beat 2 of a 5-beat packet
    @(posedge aclk);
    #1;
    send_pkt(5, 14'h0066, 1'b0, 2);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mid_rst_s_tready", s_if.tready, 1'b0);
    chk("mid_rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("mid_rst_m_tdata", m_if.tdata, '0);
    chk("mid_rst_m_route", m_route, '0);
    chk("mid_rst_pkt_cnt", pkt_cnt, '0);
    chk("mid_rst_drop_cnt", drop_cnt, '0);
    @(negedge aclk);
    chk("mid_rst_s_tready_up", s_if.tready, 1'b1);
    @(posedge aclk);
    #1;
    send_pkt(3, 14'h0077, 1'b1, 3);
    drain("mid_rst_drain", 50);
    chk("mid_rst_pkt_cnt_after", pkt_cnt, 32'd1);
    chk("mid_rst_drop_cnt_after", drop_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
